// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg : shared types and default sizing for the FIFO write arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int DEF_DSIZE     = 8;
   localparam int DEF_NREQ      = 4;
   localparam int DEF_MAX_BURST = 4;
   localparam int STAT_W        = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin winner search starting after base
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
)(
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] base,
   input  logic [NREQ-1:0]         excl,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    valid
);

   localparam int IDX_W = $clog2(NREQ);

   // Walk from the farthest candidate back to the nearest so the closest
   // eligible requester after base is the last (winning) assignment.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(base) + k) % NREQ] && !excl[(int'(base) + k) % NREQ]) begin
            idx   = IDX_W'((int'(base) + k) % NREQ);
            valid = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter for a shared FIFO write port
// Optional per-requester ack counters with FIFO_WR_ARB_STATS_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DSIZE     = DEF_DSIZE,
   parameter int NREQ      = DEF_NREQ,
   parameter int MAX_BURST = DEF_MAX_BURST
)(
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic                  wfull,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0] stat_cnt
`endif
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] last_owner;
   logic [CNT_W-1:0] burst_cnt;

   logic [IDX_W-1:0] pick_base;
   logic [NREQ-1:0]  pick_excl;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic             wr_ok;
   logic             rel;

   assign wr_ok = ~wfull & wrst_n;
   assign ack   = gnt & req & {NREQ{wr_ok}};
   assign winc  = |ack;
   assign busy  = (state == GRANT);

   always_comb begin
      wdata = '0;
      if ((|gnt) && wrst_n)
         wdata = req_data[int'(owner)*DSIZE +: DSIZE];
   end

   // Release when the owner lets go, or its last allowed word is written now.
   assign rel = busy && (!req[owner] ||
                         (winc && burst_cnt == CNT_W'(MAX_BURST - 1)));

   // In GRANT the search starts after the current owner (the last_owner value
   // taking effect at this edge) and skips it; the owner is the fallback.
   assign pick_base = busy ? owner : last_owner;
   assign pick_excl = busy ? (NREQ'(1) << owner) : '0;

   rr_pick #(
      .NREQ  (NREQ)
   ) u_rr_pick (
      .req   (req),
      .base  (pick_base),
      .excl  (pick_excl),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         state      <= IDLE;
         gnt        <= '0;
         owner      <= '0;
         last_owner <= IDX_W'(NREQ - 1);
         burst_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state     <= GRANT;
                  owner     <= pick_idx;
                  gnt       <= NREQ'(1) << pick_idx;
                  burst_cnt <= '0;
               end
            end
            GRANT: begin
               if (rel) begin
                  last_owner <= owner;
                  burst_cnt  <= '0;
                  if (pick_vld) begin
                     owner <= pick_idx;
                     gnt   <= NREQ'(1) << pick_idx;
                  end else if (!req[owner]) begin
                     state <= IDLE;
                     gnt   <= '0;
                  end
               end else if (winc) begin
                  burst_cnt <= burst_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_stat
         logic [STAT_W-1:0] cnt;
         always_ff @(posedge wclk) begin
            if (!wrst_n)
               cnt <= '0;
            else if (ack[i] && cnt != '1)
               cnt <= cnt + STAT_W'(1);
         end
         assign stat_cnt[i*STAT_W +: STAT_W] = cnt;
      end
   endgenerate
`endif

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DSIZE, 8, data word width, matching the FIFO write port.
- NREQ, 4, number of write requesters (2..8).
- MAX_BURST, 4, max words per grant before forced re-arbitration (1..16).
REQ-002 Ports SHALL be, one per line:
- wclk  input  1  sole clock.
- wrst_n  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester write request; held while data is pending.
- req_data  input  NREQ*DSIZE  packed request data; slice i = bits [i*DSIZE +: DSIZE].
- wfull  input  1  FIFO full flag.
- gnt  output  NREQ  one-hot current grant (registered).
- ack  output  NREQ  word from requester i is written this cycle.
- winc  output  1  FIFO write enable.
- wdata  output  DSIZE  FIFO write data.
- busy  output  1  high when state is GRANT.

Function
REQ-003 The FSM SHALL have two states, IDLE and GRANT, held in a registered state variable.
REQ-004 In IDLE with any req bit high, the block SHALL enter GRANT at the next wclk edge and set gnt one-hot to the round-robin winner; arbitration latency is 1 cycle.
REQ-005 The round-robin winner SHALL be the first requester with req high, searching from index last_owner+1 with modulo-NREQ wrap.
REQ-006 The block SHALL drive these outputs combinationally in every cycle:
- ack[i] = gnt[i] & req[i] & ~wfull & wrst_n.
- winc = |ack.
- wdata = req_data slice of the granted index, or 0 when gnt is 0.
REQ-007 A burst counter SHALL increment on each winc and reset to 0 on every grant change.
REQ-008 The grant SHALL be released at the wclk edge where either condition holds:
- req of the owner is low, or
- a winc occurs with the counter equal to MAX_BURST-1.
REQ-009 On release, last_owner SHALL take the released index.
- If any req is high, excluding the released owner when it still requests, the block SHALL grant the next winner in the same edge and stay in GRANT.
- Else, if only the released owner still requests, it SHALL be re-granted with the counter cleared.
- Else the block SHALL go to IDLE with gnt = 0.
REQ-010 While wfull=1, ack and winc SHALL be 0 and the grant, counter and state SHALL hold; writing resumes in the first cycle wfull=0.
REQ-011 A requester that drops req while stalled on wfull SHALL lose the grant per REQ-008 with no word written.
REQ-012 gnt SHALL never have more than one bit set, and winc SHALL never be 1 while wfull=1.

Reset
REQ-013 On a wclk edge with wrst_n=0, the block SHALL set:
- state = IDLE, gnt = 0, burst counter = 0.
- last_owner = NREQ-1, so requester 0 wins first after reset.
- stat counters = 0 (when compiled in).
REQ-014 While wrst_n=0, winc and ack SHALL be 0 and wdata SHALL be 0 combinationally, including mid-burst.
REQ-015 Reset SHALL be synchronous only; no block logic SHALL be sensitive to a wrst_n edge.

Configuration
REQ-016 With macro FIFO_WR_ARB_STATS_EN defined, the block SHALL add output stat_cnt (NREQ*16 bits).
- Slice i is a 16-bit counter of ack[i] pulses, saturating at 16'hFFFF.
REQ-017 Without FIFO_WR_ARB_STATS_EN, the stat_cnt port and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-018 Package fifo_arb_pkg SHALL hold:
- the IDLE/GRANT state typedef,
- default DSIZE/NREQ/MAX_BURST constants,
- STAT_W = 16.
REQ-019 Combinational sub-module rr_pick SHALL compute the winner index and valid flag from req, last_owner and an exclude mask.
- It SHALL be instantiated once.
REQ-020 Total RTL SHALL be 120-400 lines.

Verification
REQ-021 Reset, then req=4'b0001 with data 8'hA1 held -> gnt=0001 one cycle later; winc=1, wdata=A1 for 4 cycles.
- Then re-grant to req0 with the counter cleared (no other requesters).
REQ-022 req=4'b1111 held, wfull=0 -> grants in order 0,1,2,3,0, each for exactly 4 winc cycles, no idle cycles between grants.
REQ-023 req0 granted, wfull=1 for 5 cycles mid-burst -> winc=0 during the stall; burst count preserved; the remaining words are written after wfull falls.
- Total words for the grant = 4.
REQ-024 wrst_n=0 asserted during a burst -> winc=0 in the same cycle; gnt=0 and state=IDLE after the edge.
- The next grant goes to requester 0.
REQ-025 req2 drops after 2 words with req1 pending -> gnt switches to req1 at that edge; last_owner = 2.
REQ-026 With FIFO_WR_ARB_STATS_EN, 10 words from req3 -> stat_cnt slice 3 = 10, other slices 0.
- Counters are 0 after reset.
